uart_tx_serializer: RTL

- Consumes the one-cycle baud enable pulse (`baud_tick`) from the upstream tick generator and serializes parallel bytes onto a UART TX line.
- Frame format, in order: start bit, DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits.
- Sits between the byte producer (valid/ready handshake) and the board TX pin.
- Each bit lasts exactly one `baud_tick` period.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_serializer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmitter: frames bytes as start, LSB-first data, optional parity, stop,
// advancing one bit per baud_tick. Handshake: a byte moves when tx_valid && tx_ready.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              ODD_SEL   = (PARITY_ODD != 0);

  tx_state_t              state_q, state_d;
  logic                   tx_q, tx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   parity_q, parity_d;
  logic [MAX_DATA_BITS-1:0] data_ext;

  assign data_ext = MAX_DATA_BITS'(tx_data);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          shreg_d  = tx_data;
          parity_d = calc_parity(data_ext, ODD_SEL);
          state_d  = SYNC;
        end
      end
      // The accept cycle's tick is never seen here, so the start bit spans a full period.
      SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_d      = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          tx_d = 1'b1;
          if (stop_cnt_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;

endmodule
